// File: rtl/current_limit_monitor.sv
// rtl/current_limit_monitor.sv - multi-channel over-current monitor with hysteresis, debounce, sticky trip and peak hold
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   sample_valid      : all channels' samples valid this cycle
//   sample_data       : channel c at [c*DATA_W +: DATA_W]
//   ch_enable         : per-channel monitor enable
//   limit_wr/sel/data : per-channel limit write; limit_sel also selects peak readback
//   status_clear      : per-channel clear of trip, debounce count and peak
//   over_limit        : live over-limit flag (with hysteresis)
//   trip              : sticky trip flags
//   trip_event        : one-cycle pulse when any trip bit rises
//   shutdown_n        : registered, low while any trip is set
//   peak_data         : registered peak of channel limit_sel (0 if out of range)
module current_limit_monitor #(
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 16,
  parameter int HYST         = 16,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     limit_wr,
  input  logic [2:0]               limit_sel,
  input  logic [DATA_W-1:0]        limit_data,
  input  logic [NUM_CH-1:0]        status_clear,
  output logic [NUM_CH-1:0]        over_limit,
  output logic [NUM_CH-1:0]        trip,
  output logic                     trip_event,
  output logic                     shutdown_n,
  output logic [DATA_W-1:0]        peak_data
);

  localparam logic [DATA_W-1:0] HYST_V = DATA_W'(HYST);
  localparam logic [3:0]        DB     = 4'(DEBOUNCE_CNT);

  logic [DATA_W-1:0] limit   [NUM_CH];
  logic [DATA_W-1:0] peak    [NUM_CH];
  logic [3:0]        cnt     [NUM_CH];

  logic [DATA_W-1:0] smp     [NUM_CH];
  logic [DATA_W-1:0] rel     [NUM_CH];
  logic [DATA_W-1:0] peak_nx [NUM_CH];
  logic [3:0]        cnt_nx  [NUM_CH];
  logic [NUM_CH-1:0] ol_nx;
  logic [NUM_CH-1:0] trip_nx;
  logic [NUM_CH-1:0] trip_set;
  logic [DATA_W-1:0] peak_rd;

  // Release threshold saturates at 0 so a low limit can only be released by a zero sample.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign smp[g] = sample_data[g*DATA_W +: DATA_W];
    assign rel[g] = (limit[g] > HYST_V) ? (limit[g] - HYST_V) : '0;
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_nx[c]   = status_clear[c] ? 4'd0 : cnt[c];
      ol_nx[c]    = over_limit[c];
      peak_nx[c]  = status_clear[c] ? '0 : peak[c];
      trip_set[c] = 1'b0;
      if (!ch_enable[c]) begin
        cnt_nx[c] = 4'd0;
        ol_nx[c]  = 1'b0;
      end else if (sample_valid) begin
        // A valid sample overrides a same-cycle clear: the counter follows the
        // sample from its current value, so a saturated counter re-trips.
        if (smp[c] > limit[c]) begin
          ol_nx[c]    = 1'b1;
          cnt_nx[c]   = (cnt[c] >= DB) ? DB : cnt[c] + 4'd1;
          trip_set[c] = (cnt_nx[c] == DB);
        end else if (smp[c] <= rel[c]) begin
          ol_nx[c]  = 1'b0;
          cnt_nx[c] = 4'd0;
        end else begin
          cnt_nx[c] = cnt[c];
        end
        if (smp[c] > peak_nx[c]) peak_nx[c] = smp[c];
      end
      trip_nx[c] = (trip[c] & ~status_clear[c]) | trip_set[c];
    end
  end

  always_comb begin
    peak_rd = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (limit_sel == 3'(c)) peak_rd = peak[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        limit[c] <= '1;
        peak[c]  <= '0;
        cnt[c]   <= 4'd0;
      end
      over_limit <= '0;
      trip       <= '0;
      trip_event <= 1'b0;
      shutdown_n <= 1'b1;
      peak_data  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (limit_wr && limit_sel == 3'(c)) limit[c] <= limit_data;
        peak[c] <= peak_nx[c];
        cnt[c]  <= cnt_nx[c];
      end
      over_limit <= ol_nx;
      trip       <= trip_nx;
      trip_event <= |(trip_nx & ~trip);
      shutdown_n <= ~|trip;
      peak_data  <= peak_rd;
    end
  end

endmodule

// File: tb/tb_current_limit_monitor.sv
// tb/tb_current_limit_monitor.sv - scoreboard-driven directed bench for current_limit_monitor
module tb_current_limit_monitor;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 16;

  localparam int S_OL = 0, S_TRIP = 1, S_EVT = 2, S_SDN = 3, S_PEAK = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     sample_valid = 1'b0;
  logic [NUM_CH*DATA_W-1:0] sample_data = '0;
  logic [NUM_CH-1:0]        ch_enable = '1;
  logic                     limit_wr = 1'b0;
  logic [2:0]               limit_sel = 3'd0;
  logic [DATA_W-1:0]        limit_data = '0;
  logic [NUM_CH-1:0]        status_clear = '0;
  logic [NUM_CH-1:0]        over_limit;
  logic [NUM_CH-1:0]        trip;
  logic                     trip_event;
  logic                     shutdown_n;
  logic [DATA_W-1:0]        peak_data;

  current_limit_monitor #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .HYST(16), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .ch_enable(ch_enable), .limit_wr(limit_wr), .limit_sel(limit_sel),
    .limit_data(limit_data), .status_clear(status_clear), .over_limit(over_limit),
    .trip(trip), .trip_event(trip_event), .shutdown_n(shutdown_n), .peak_data(peak_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic push(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sig = sig; e.exp = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_OL:    return 32'(over_limit);
      S_TRIP:  return 32'(trip);
      S_EVT:   return 32'(trip_event);
      S_SDN:   return 32'(shutdown_n);
      default: return 32'(peak_data);
    endcase
  endfunction

  // Advance one edge, then retire every expectation queued for it.
  task automatic tick();
    exp_t        e;
    logic [31:0] obs;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      applied++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic samp(input logic [15:0] v0, input logic [15:0] v1);
    sample_valid = 1'b1;
    sample_data  = {v1, v0};
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wr_limit(input logic [2:0] sel, input logic [15:0] val);
    limit_wr = 1'b1; limit_sel = sel; limit_data = val;
    tick();
    limit_wr = 1'b0; limit_sel = 3'd0;
  endtask

  task automatic clear_samp(input logic [1:0] clr, input logic [15:0] v0, input logic [15:0] v1);
    status_clear = clr;
    samp(v0, v1);
    status_clear = '0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    push("rst_ol", S_OL, 0); push("rst_trip", S_TRIP, 0); push("rst_evt", S_EVT, 0);
    push("rst_sdn", S_SDN, 1); push("rst_peak", S_PEAK, 0);
    tick();
    rst = 1'b0;

    // 1. Trip after debounce
    wr_limit(3'd0, 16'd1000);
    push("t1_ol1", S_OL, 1); push("t1_trip1", S_TRIP, 0);
    samp(16'd1001, 16'd0);
    push("t1_trip2", S_TRIP, 0);
    samp(16'd1001, 16'd0);
    push("t1_trip3", S_TRIP, 1); push("t1_evt", S_EVT, 1); push("t1_sdn_hi", S_SDN, 1);
    samp(16'd1001, 16'd0);
    push("t1_sdn_lo", S_SDN, 0); push("t1_evt_once", S_EVT, 0); push("t1_trip_sticky", S_TRIP, 1);
    tick();
    status_clear = 2'b01;
    push("t1_clr_trip", S_TRIP, 0); push("t1_clr_sdn", S_SDN, 0);
    tick();
    status_clear = '0;
    push("t1_sdn_back", S_SDN, 1);
    tick();
    push("t1_release", S_OL, 0);
    samp(16'd0, 16'd0);

    // 2. Hysteresis hold and reset
    samp(16'd1001, 16'd0);
    samp(16'd1001, 16'd0);
    push("t2_hold_ol", S_OL, 1); push("t2_hold_trip", S_TRIP, 0);
    samp(16'd990, 16'd0);
    push("t2_trip_after_hold", S_TRIP, 1);
    samp(16'd1001, 16'd0);
    push("t2_clr0", S_TRIP, 0);
    clear_samp(2'b01, 16'd0, 16'd0);
    samp(16'd1001, 16'd0);
    samp(16'd1001, 16'd0);
    push("t2_rel_ol", S_OL, 0);
    samp(16'd984, 16'd0);
    samp(16'd1001, 16'd0);
    push("t2_no_trip", S_TRIP, 0);
    samp(16'd1001, 16'd0);
    push("t2_trip_third", S_TRIP, 1);
    samp(16'd1001, 16'd0);
    clear_samp(2'b01, 16'd0, 16'd0);
    tick();

    // 3. Clear/set collision on ch1
    wr_limit(3'd1, 16'd1000);
    samp(16'd0, 16'd2000);
    samp(16'd0, 16'd2000);
    push("t3_trip", S_TRIP, 2);
    samp(16'd0, 16'd2000);
    samp(16'd0, 16'd2000);
    push("t3_set_wins", S_TRIP, 2); push("t3_no_evt", S_EVT, 0);
    clear_samp(2'b10, 16'd0, 16'd2000);
    push("t3_cleared", S_TRIP, 0); push("t3_sdn_still_lo", S_SDN, 0);
    clear_samp(2'b10, 16'd0, 16'd0);
    push("t3_sdn_hi", S_SDN, 1);
    tick();

    // 4. Enable masking on ch0
    wr_limit(3'd0, 16'd100);
    ch_enable = 2'b10;
    for (int i = 0; i < 10; i++) begin
      push("t4_masked_ol", S_OL, 0); push("t4_masked_trip", S_TRIP, 0);
      samp(16'hFFFE, 16'd0);
    end
    push("t4_peak_unchanged", S_PEAK, 0);
    tick();
    ch_enable = 2'b11;
    samp(16'hFFFE, 16'd0);
    push("t4_reen_no_trip", S_TRIP, 0);
    samp(16'hFFFE, 16'd0);
    push("t4_reen_trip", S_TRIP, 1);
    samp(16'hFFFE, 16'd0);
    push("t4_peak0", S_PEAK, 16'hFFFE);
    tick();
    clear_samp(2'b01, 16'd0, 16'd0);
    tick();

    // 5. Peak and readback on ch1
    limit_sel = 3'd1;
    samp(16'd0, 16'd500);
    samp(16'd0, 16'd1200);
    samp(16'd0, 16'd800);
    push("t5_peak1", S_PEAK, 1200);
    tick();
    limit_sel = 3'd5;
    push("t5_sel_oob", S_PEAK, 0);
    tick();
    limit_sel = 3'd1;
    status_clear = 2'b10;
    tick();
    status_clear = '0;
    push("t5_peak_cleared", S_PEAK, 0);
    tick();
    limit_sel = 3'd0;

    // 6. Limit write collision, then reset mid-debounce
    limit_wr = 1'b1; limit_sel = 3'd0; limit_data = 16'd50;
    push("t6_old_limit", S_OL, 0);
    samp(16'd60, 16'd0);
    limit_wr = 1'b0;
    push("t6_new_limit", S_OL, 1);
    samp(16'd60, 16'd0);
    samp(16'd60, 16'd0);
    rst = 1'b1;
    push("t6_rst_ol", S_OL, 0); push("t6_rst_trip", S_TRIP, 0);
    push("t6_rst_sdn", S_SDN, 1); push("t6_rst_evt", S_EVT, 0);
    tick();
    rst = 1'b0;
    push("t6_allones_limit", S_OL, 0);
    samp(16'd0, 16'hFFFF);
    wr_limit(3'd0, 16'd50);
    samp(16'd60, 16'd0);
    push("t6_restart_no_trip", S_TRIP, 0);
    samp(16'd60, 16'd0);
    push("t6_restart_trip", S_TRIP, 1); push("t6_restart_evt", S_EVT, 1);
    samp(16'd60, 16'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
